// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, NUM_RD combinational read ports with
// write-through bypass, a pending-producer scoreboard and a post-reset clearing sweep.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  output logic                     init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic ready;
  logic wr0, wr1, rsv;

  assign ready     = (state_q == StReady);
  assign init_done = ready;

  // Address 0 is hard-wired zero; a same-address pair keeps only port 1.
  assign wr1 = ready & we1 & (waddr1 != '0);
  assign wr0 = ready & we0 & (waddr0 != '0) & ~(wr1 & (waddr1 == waddr0));
  assign rsv = ready & resv_en & (resv_addr != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = StReady;
      end
      StReady: begin
        if (wr0) pend_d[waddr0] = 1'b0;
        if (wr1) pend_d[waddr1] = 1'b0;
        // Set after the clears so a new producer wins over a retiring one.
        if (rsv) pend_d[resv_addr] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        regs[cnt_q] <= '0;
      end else begin
        if (wr0) regs[waddr0] <= wdata0;
        if (wr1) regs[waddr1] <= wdata1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              en, hit0, hit1;

    assign ra   = raddr[g*ADDR_W +: ADDR_W];
    assign en   = ready & re[g] & (ra != '0);
    assign hit1 = we1 & (waddr1 == ra);
    assign hit0 = we0 & (waddr0 == ra);

    assign rdata[g*DATA_W +: DATA_W] = !en  ? '0     :
                                       hit1 ? wdata1 :
                                       hit0 ? wdata0 : regs[ra];
    assign rbusy[g] = en & pend_q[ra] & ~hit1 & ~hit0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a reference model feeds a scoreboard queue every cycle, and
// directed scenarios add fixed expectations to the same queue.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        resv_en;
  logic [4:0]  resv_addr;
  logic        init_done;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .we1       (we1),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;  // 0 rdata0, 1 rdata1, 2 rbusy, 3 init_done
    logic [31:0] val;
  } exp_t;

  exp_t        sq[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] mm [32];
  logic [31:0] mpend;
  bit          mready;
  int          mcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sq.push_back(e);
  endtask

  function automatic logic [31:0] exp_rd(input int p);
    logic [4:0] a;
    a = raddr[p*5 +: 5];
    if (!mready || !re[p] || a == 5'd0) return 32'd0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return mm[a];
  endfunction

  function automatic logic exp_busy(input int p);
    logic [4:0] a;
    a = raddr[p*5 +: 5];
    if (!mready || !re[p] || a == 5'd0) return 1'b0;
    if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
    return mpend[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      mready = 1'b0;
      mcnt   = 0;
      mpend  = '0;
    end else if (!mready) begin
      mm[mcnt] = '0;
      if (mcnt == 31) begin
        mready = 1'b1;
        mcnt   = 0;
      end else begin
        mcnt++;
      end
    end else begin
      if (we0 && waddr0 != 5'd0) begin mm[waddr0] = wdata0; mpend[waddr0] = 1'b0; end
      if (we1 && waddr1 != 5'd0) begin mm[waddr1] = wdata1; mpend[waddr1] = 1'b0; end
      if (resv_en && resv_addr != 5'd0) mpend[resv_addr] = 1'b1;
    end
  endtask

  // One clock: queue model expectations, compare mid-cycle, then advance the model.
  task automatic step();
    logic [31:0] obs [4];
    exp_t        e;
    push_exp("rdata0", 0, exp_rd(0));
    push_exp("rdata1", 1, exp_rd(1));
    push_exp("rbusy", 2, {30'd0, exp_busy(1), exp_busy(0)});
    push_exp("init_done", 3, {31'd0, mready});
    @(negedge clk);
    obs[0] = rdata[31:0];
    obs[1] = rdata[63:32];
    obs[2] = {30'd0, rbusy};
    obs[3] = {31'd0, init_done};
    while (sq.size() > 0) begin
      e = sq.pop_front();
      check_val(e.tag, obs[e.sel], e.val);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = '0; raddr = '0; resv_en = 1'b0; resv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    re[p] = 1'b1;
    raddr[p*5 +: 5] = a;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    mpend  = '0;
    mready = 1'b0;
    mcnt   = 0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    rst = 1'b0;

    // Clear sweep with idle bus: reads zero, init_done rises after 32 edges.
    for (int j = 0; j <= 32; j++) begin
      set_rd(0, 5'(j));
      set_rd(1, 5'(31 - j));
      if (j == 31) push_exp("init_pre", 3, 32'd0);
      if (j == 32) push_exp("init_rise", 3, 32'd1);
      step();
    end
    for (int j = 0; j < 32; j += 4) begin
      idle();
      set_rd(0, 5'(j));
      set_rd(1, 5'(j + 1));
      push_exp("cleared0", 0, 32'd0);
      push_exp("cleared1", 1, 32'd0);
      step();
    end

    // Same-cycle write bypass, then registered value.
    idle();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_rd(0, 5'd5);
    push_exp("byp_w0", 0, 32'hDEADBEEF);
    step();
    we0 = 1'b0;
    push_exp("held_5", 0, 32'hDEADBEEF);
    step();

    // Dual write to one address: port 1 wins.
    idle();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    set_rd(0, 5'd7); set_rd(1, 5'd7);
    push_exp("dual_byp0", 0, 32'h22222222);
    push_exp("dual_byp1", 1, 32'h22222222);
    step();
    we0 = 1'b0; we1 = 1'b0;
    push_exp("dual_reg0", 0, 32'h22222222);
    push_exp("dual_reg1", 1, 32'h22222222);
    step();

    // Reservation, busy, then retiring write.
    idle();
    resv_en = 1'b1; resv_addr = 5'd9;
    step();
    idle();
    set_rd(1, 5'd9);
    push_exp("busy_9", 2, 32'd2);
    step();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hA5A5A5A5;
    push_exp("retire_busy", 2, 32'd0);
    push_exp("retire_data", 1, 32'hA5A5A5A5);
    step();
    we1 = 1'b0;
    push_exp("after_busy", 2, 32'd0);
    push_exp("after_data", 1, 32'hA5A5A5A5);
    step();

    // Address 0 ignores writes and reservations.
    idle();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    resv_en = 1'b1; resv_addr = 5'd0;
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    push_exp("zero_byp", 0, 32'd0);
    step();
    idle();
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    push_exp("zero_rd", 1, 32'd0);
    push_exp("zero_busy", 2, 32'd0);
    step();

    // Reservation and write to one address in one cycle: still pending after.
    idle();
    resv_en = 1'b1; resv_addr = 5'd12;
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0BADF00D;
    step();
    idle();
    set_rd(0, 5'd12); set_rd(1, 5'd12);
    push_exp("resv_wins", 2, 32'd3);
    push_exp("resv_data", 0, 32'h0BADF00D);
    step();

    // Random traffic on a small address range to force collisions.
    for (int k = 0; k < 150; k++) begin
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 1));
      waddr0    = 5'($urandom_range(0, 7));
      waddr1    = 5'($urandom_range(0, 7));
      wdata0    = $urandom();
      wdata1    = $urandom();
      resv_en   = 1'($urandom_range(0, 1));
      resv_addr = 5'($urandom_range(0, 7));
      re        = 2'($urandom_range(0, 3));
      raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end

    // Reset in READY, restart mid-sweep with writes attempted throughout.
    idle();
    resv_en = 1'b1; resv_addr = 5'd20;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = $urandom();
      resv_en = 1'b1; resv_addr = 5'd5;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 100) begin
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = $urandom();
      step();
      n++;
    end
    check_val("init_latency", n, 32);
    idle();
    set_rd(0, 5'd5); set_rd(1, 5'd7);
    push_exp("rst_clr5", 0, 32'd0);
    push_exp("rst_clr7", 1, 32'd0);
    push_exp("rst_nobusy", 2, 32'd0);
    step();
    idle();
    set_rd(0, 5'd9); set_rd(1, 5'd20);
    push_exp("rst_clr9", 0, 32'd0);
    push_exp("rst_pend20", 2, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports we0/we1  input  1 each  write-enable, write ports 0 and 1.
REQ-007 SHALL have ports waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W each  write data.
REQ-009 SHALL have port re  input  NUM_RD  per-port read enable.
REQ-010 SHALL have port raddr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port rbusy  output  NUM_RD  per-port pending-producer flag.
REQ-013 SHALL have ports resv_en  input  1  and resv_addr  input  ADDR_W  scoreboard reservation request.
REQ-014 SHALL have port init_done  output  1  high once the clear sweep completes.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, READY.
REQ-016 In CLEAR: each cycle write 0 to regs[cnt], cnt increments by 1; after regs[DEPTH-1] is written, next state READY, cnt returns to 0.
REQ-017 In CLEAR: we0, we1, resv_en ignored; all rdata 0; all rbusy 0; init_done 0.
REQ-018 In READY: init_done 1; cnt held.
REQ-019 Register 0 SHALL read 0 always; writes and reservations to address 0 discarded.
REQ-020 Writes: regs[waddrN] <= wdataN at rising edge when weN=1, READY, waddrN != 0.
REQ-021 Both write ports to the same nonzero address in one cycle: port 1 data stored, port 0 dropped.
REQ-022 Reads combinational, zero latency: rdata_i = 0 if re[i]=0 or raddr_i=0; else bypass; else regs[raddr_i].
REQ-023 Bypass: if we1 & waddr1==raddr_i, return wdata1; else if we0 & waddr0==raddr_i, return wdata0 (same-cycle write visible).
REQ-024 Scoreboard: DEPTH-bit pend vector; resv_en sets pend[resv_addr] at rising edge.
REQ-025 An accepted write to address A clears pend[A] at the same edge.
REQ-026 Reservation and write to same address in one cycle: pend ends set (new producer wins).
REQ-027 rbusy[i] = re[i] & pend[raddr_i] & no bypass hit on port i & raddr_i != 0; combinational.
REQ-028 Read ports mutually independent; any number may address the same register.

Reset
REQ-029 rst=1 at a rising edge: state <= CLEAR, cnt <= 0, pend <= all 0; init_done reads 0 from the following cycle.
REQ-030 rst asserted mid-CLEAR restarts the sweep at address 0; rst asserted in READY discards all pending reservations.
REQ-031 After rst deasserts, init_done SHALL rise exactly DEPTH cycles later (32 for defaults).

Verification
REQ-032 Reset then idle: init_done 0 for 32 cycles, 1 on cycle 33; every raddr reads 0x00000000.
REQ-033 we0=1, waddr0=5, wdata0=0xDEADBEEF, re[0]=1, raddr0=5 same cycle -> rdata0=0xDEADBEEF that cycle; next cycle with we0=0 still 0xDEADBEEF.
REQ-034 we0 (addr 7, 0x11111111) and we1 (addr 7, 0x22222222) together -> both ports read addr 7 = 0x22222222 then and afterwards.
REQ-035 resv_en, addr 9; next cycle re[1]=1, raddr1=9 -> rbusy[1]=1; we1 to 9 with 0xA5A5A5A5 -> rbusy[1]=0, rdata1=0xA5A5A5A5 that cycle; pend[9] clear after.
REQ-036 Write 0xFFFFFFFF to addr 0 and resv_en addr 0 -> rdata reads 0, rbusy 0.
REQ-037 rst pulsed at sweep cycle 10 -> writes ignored until init_done; init_done rises 32 cycles after rst deasserts; previously written registers read 0.
